// File: rtl/bf_sequencer_if.sv
// bf_sequencer_if
//  Bundles the sequencer's three buses: program ROM fetch, tape datapath strobes,
//  and the host byte I/O handshakes.
//  master : sequencer side (drives address/strobes/handshake outputs)
//  slave  : environment side (ROM, tape datapath, host)
interface bf_sequencer_if #(
  parameter int PC_W   = 8,
  parameter int DATA_W = 8
);
  // program ROM
  logic [PC_W-1:0]   pc_addr;
  logic              prog_re;
  logic [3:0]        instr;
  // tape datapath
  logic              t_next, t_prev, t_inc, t_dec, t_rd, t_wr;
  logic [DATA_W-1:0] t_rdata;
  logic [DATA_W-1:0] t_wdata;
  // host output / input
  logic              out_valid, out_ready;
  logic [DATA_W-1:0] out_data;
  logic              in_valid, in_ready;
  logic [DATA_W-1:0] in_data;

  modport master (
    output pc_addr, prog_re, t_next, t_prev, t_inc, t_dec, t_rd, t_wr, t_wdata,
           out_valid, out_data, in_ready,
    input  instr, t_rdata, out_ready, in_valid, in_data
  );
  modport slave (
    input  pc_addr, prog_re, t_next, t_prev, t_inc, t_dec, t_rd, t_wr, t_wdata,
           out_valid, out_data, in_ready,
    output instr, t_rdata, out_ready, in_valid, in_data
  );
endinterface

// File: rtl/bf_sequencer.sv
// bf_sequencer
//  Instruction sequencer for the 8-op tape machine. Fetches 4-bit words from a
//  synchronous program ROM, decodes them into one-cycle tape strobes, runs the
//  host I/O handshakes and resolves '[' / ']' by scanning the program with a
//  bracket-depth counter.
//  Ports:
//   clk, rst  clock / synchronous active-high reset
//   start_i   begin execution from pc 0 (honoured only in IDLE/HALT/ERR)
//   bus       ROM, tape and host I/O signals (bf_sequencer_if.master)
//   busy_o    running (not IDLE/HALT/ERR)
//   halted_o  halt word reached
//   err_o     bracket mismatch / depth overflow, sticky until start or reset
module bf_sequencer #(
  parameter int PC_W    = 8,
  parameter int DATA_W  = 8,
  parameter int DEPTH_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  bf_sequencer_if.master   bus,
  output logic             busy_o,
  output logic             halted_o,
  output logic             err_o
);
  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_DECODE, S_RDWAIT, S_OUT_HS, S_IN_HS,
    S_SCAN_F, S_SCAN_FC, S_SCAN_B, S_SCAN_BC, S_HALT, S_ERR
  } state_t;

  state_t              state_q, state_d;
  logic [PC_W-1:0]     pc_q, pc_d;
  logic [DEPTH_W-1:0]  depth_q, depth_d;
  logic [2:0]          op_q, op_d;
  logic [DATA_W-1:0]   out_data_q, out_data_d;
  logic                halted_q, halted_d;
  logic                err_q, err_d;

  logic [PC_W-1:0]     pc_inc, pc_dec;
  logic                pc_max, pc_zero, depth_max;
  logic                w_open, w_close;
  logic [DEPTH_W-1:0]  nd;

  assign pc_inc    = pc_q + 1'b1;
  assign pc_dec    = pc_q - 1'b1;
  assign pc_max    = &pc_q;
  assign pc_zero   = (pc_q == '0);
  assign depth_max = &depth_q;
  // halt words never count as brackets while scanning
  assign w_open    = !bus.instr[3] && (bus.instr[2:0] == 3'd6);
  assign w_close   = !bus.instr[3] && (bus.instr[2:0] == 3'd7);

  assign bus.pc_addr  = pc_q;
  assign bus.out_data = out_data_q;
  assign bus.t_wdata  = bus.in_data;
  assign halted_o     = halted_q;
  assign err_o        = err_q;
  assign busy_o       = !(state_q inside {S_IDLE, S_HALT, S_ERR});

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      pc_q       <= '0;
      depth_q    <= '0;
      op_q       <= '0;
      out_data_q <= '0;
      halted_q   <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      depth_q    <= depth_d;
      op_q       <= op_d;
      out_data_q <= out_data_d;
      halted_q   <= halted_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    depth_d       = depth_q;
    op_d          = op_q;
    out_data_d    = out_data_q;
    halted_d      = halted_q;
    err_d         = err_q;
    nd            = depth_q;
    bus.prog_re   = 1'b0;
    bus.t_next    = 1'b0;
    bus.t_prev    = 1'b0;
    bus.t_inc     = 1'b0;
    bus.t_dec     = 1'b0;
    bus.t_rd      = 1'b0;
    bus.t_wr      = 1'b0;
    bus.out_valid = 1'b0;
    bus.in_ready  = 1'b0;

    unique case (state_q)
      S_IDLE, S_HALT, S_ERR: begin
        if (start_i) begin
          pc_d     = '0;
          depth_d  = '0;
          halted_d = 1'b0;
          err_d    = 1'b0;
          state_d  = S_FETCH;
        end
      end
      S_FETCH: begin
        bus.prog_re = 1'b1;
        state_d     = S_DECODE;
      end
      S_DECODE: begin
        if (bus.instr[3]) begin
          halted_d = 1'b1;
          state_d  = S_HALT;
        end else begin
          op_d = bus.instr[2:0];
          unique case (bus.instr[2:0])
            3'd0: begin bus.t_next = 1'b1; pc_d = pc_inc; state_d = S_FETCH; end
            3'd1: begin bus.t_prev = 1'b1; pc_d = pc_inc; state_d = S_FETCH; end
            3'd2: begin bus.t_inc  = 1'b1; pc_d = pc_inc; state_d = S_FETCH; end
            3'd3: begin bus.t_dec  = 1'b1; pc_d = pc_inc; state_d = S_FETCH; end
            3'd5: state_d = S_IN_HS;
            default: begin bus.t_rd = 1'b1; state_d = S_RDWAIT; end  // '.', '[', ']'
          endcase
        end
      end
      S_RDWAIT: begin
        unique case (op_q)
          3'd4: begin
            out_data_d = bus.t_rdata;
            state_d    = S_OUT_HS;
          end
          3'd6: begin
            if (bus.t_rdata != '0) begin
              pc_d = pc_inc; state_d = S_FETCH;
            end else if (pc_max) begin
              err_d = 1'b1; state_d = S_ERR;
            end else begin
              depth_d = 1; pc_d = pc_inc; state_d = S_SCAN_F;
            end
          end
          3'd7: begin
            if (bus.t_rdata == '0) begin
              pc_d = pc_inc; state_d = S_FETCH;
            end else if (pc_zero) begin
              err_d = 1'b1; state_d = S_ERR;
            end else begin
              depth_d = 1; pc_d = pc_dec; state_d = S_SCAN_B;
            end
          end
          default: state_d = S_FETCH;
        endcase
      end
      S_OUT_HS: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) begin pc_d = pc_inc; state_d = S_FETCH; end
      end
      S_IN_HS: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) begin
          bus.t_wr = 1'b1; pc_d = pc_inc; state_d = S_FETCH;
        end
      end
      S_SCAN_F, S_SCAN_B: begin
        bus.prog_re = 1'b1;
        state_d     = (state_q == S_SCAN_F) ? S_SCAN_FC : S_SCAN_BC;
      end
      S_SCAN_FC, S_SCAN_BC: begin
        // same counter both directions; only which bracket nests flips
        if ((state_q == S_SCAN_FC) ? w_open : w_close) begin
          nd = depth_q + 1'b1;
        end else if ((state_q == S_SCAN_FC) ? w_close : w_open) begin
          nd = depth_q - 1'b1;
        end
        depth_d = nd;
        if (((state_q == S_SCAN_FC) ? w_open : w_close) && depth_max) begin
          err_d = 1'b1; state_d = S_ERR;
        end else if (nd == '0) begin
          // matching bracket found: resume just past it
          pc_d = pc_inc; state_d = S_FETCH;
        end else if (state_q == S_SCAN_FC) begin
          if (pc_max) begin err_d = 1'b1; state_d = S_ERR; end
          else begin pc_d = pc_inc; state_d = S_SCAN_F; end
        end else begin
          if (pc_zero) begin err_d = 1'b1; state_d = S_ERR; end
          else begin pc_d = pc_dec; state_d = S_SCAN_B; end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end
endmodule

// File: tb/tb_bf_sequencer.sv
// tb_bf_sequencer
//  Directed bench: sync ROM model, tape model (16 cells, pointer), strobe counters,
//  hand-computed expectations for each program.
module tb_bf_sequencer;
  localparam int PC_W = 8, DATA_W = 8;

  logic clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic busy, halted, err;
  always #5 clk = ~clk;

  bf_sequencer_if #(.PC_W(PC_W), .DATA_W(DATA_W)) bus ();
  bf_sequencer #(.PC_W(PC_W), .DATA_W(DATA_W), .DEPTH_W(4)) dut (
    .clk(clk), .rst(rst), .start_i(start), .bus(bus),
    .busy_o(busy), .halted_o(halted), .err_o(err)
  );

  int checks = 0, failures = 0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ROM: word valid on instr the cycle after prog_re
  logic [3:0] rom [0:255];
  always @(posedge clk) if (bus.prog_re) bus.instr <= rom[bus.pc_addr];

  // tape model
  logic [7:0] tape [0:15];
  logic [3:0] ptr;
  logic [7:0] init_cell = 8'h0;
  int n_next, n_prev, n_inc, n_dec, n_wr, n_out, n_multi, n_fetch2;
  logic [7:0] last_wdata;
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) tape[i] <= 8'h0;
      tape[0] <= init_cell;
      ptr <= 4'h0; bus.t_rdata <= 8'h0;
      n_next <= 0; n_prev <= 0; n_inc <= 0; n_dec <= 0; n_wr <= 0;
      n_out <= 0; n_multi <= 0; n_fetch2 <= 0; last_wdata <= 8'h0;
    end else begin
      if (bus.t_next) begin ptr <= ptr + 1'b1; n_next <= n_next + 1; end
      if (bus.t_prev) begin ptr <= ptr - 1'b1; n_prev <= n_prev + 1; end
      if (bus.t_inc)  begin tape[ptr] <= tape[ptr] + 1'b1; n_inc <= n_inc + 1; end
      if (bus.t_dec)  begin tape[ptr] <= tape[ptr] - 1'b1; n_dec <= n_dec + 1; end
      if (bus.t_wr)   begin tape[ptr] <= bus.t_wdata; last_wdata <= bus.t_wdata; n_wr <= n_wr + 1; end
      if (bus.t_rd)   bus.t_rdata <= tape[ptr];
      if (bus.out_valid && bus.out_ready) n_out <= n_out + 1;
      if (bus.prog_re && bus.pc_addr == 8'd2) n_fetch2 <= n_fetch2 + 1;
      if (32'(bus.t_next) + 32'(bus.t_prev) + 32'(bus.t_inc) + 32'(bus.t_dec)
          + 32'(bus.t_rd) + 32'(bus.t_wr) > 1) n_multi <= n_multi + 1;
    end
  end

  // words[4*i +: 4] is ROM word i; everything past n is a halt word
  task automatic load_rom(input logic [31:0] words, input int n);
    for (int i = 0; i < 256; i++) rom[i] = 4'h8;
    for (int i = 0; i < n; i++) rom[i] = words[4*i +: 4];
  endtask

  task automatic do_reset(input logic [7:0] cell0);
    init_cell = cell0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // returns at the first negedge after the edge that sampled start
  task automatic go();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int lim);
    int k = 0;
    while (!halted && !err && k < lim) begin @(negedge clk); k++; end
    chk({tag, "_timeout"}, 32'(k < lim), 32'd1);
  endtask

  task automatic wait_sig(input string tag, input int which, input int lim);
    int k = 0;
    while (!((which == 0) ? bus.out_valid : bus.in_ready) && k < lim) begin @(negedge clk); k++; end
    chk({tag, "_timeout"}, 32'(k < lim), 32'd1);
  endtask

  logic [3:0] exp_s;

  initial begin
    bus.out_ready = 1'b0; bus.in_valid = 1'b0; bus.in_data = 8'h0; bus.instr = 4'h0;
    load_rom(32'h0, 0);

    // reset state
    do_reset(8'h0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_flags", {halted, err, bus.out_valid, bus.in_ready}, 0);
    chk("rst_strb", {bus.t_next, bus.t_prev, bus.t_inc, bus.t_dec, bus.t_rd, bus.t_wr, bus.prog_re}, 0);
    chk("rst_out", 32'(bus.out_data), 0);
    chk("rst_pc", 32'(bus.pc_addr), 0);

    // 1: "+ + > -" then halt; sample i = spec cycle - 2
    do_reset(8'h0);
    load_rom(32'h3022, 4);
    go();
    for (int i = 0; i <= 10; i++) begin
      exp_s = (i == 1 || i == 3) ? 4'b0010 : (i == 5) ? 4'b1000 : (i == 7) ? 4'b0001 : 4'b0000;
      chk($sformatf("t1_strb%0d", i), {bus.t_next, bus.t_prev, bus.t_inc, bus.t_dec}, exp_s);
      if (i == 10) chk("t1_halt", {halted, busy}, 2'b10);
      @(negedge clk);
    end
    chk("t1_tape", {tape[0], tape[1]}, 16'h02FF);

    // 2: "." with back-pressure
    do_reset(8'h41);
    load_rom(32'h4, 1);
    go();
    wait_sig("t2_ov", 0, 10);
    repeat (5) begin
      chk("t2_hold", {bus.out_valid, bus.out_data}, 9'h141);
      @(negedge clk);
    end
    bus.out_ready = 1'b1;
    @(negedge clk) bus.out_ready = 1'b0;
    chk("t2_drop", 32'(bus.out_valid), 0);
    wait_done("t2", 20);
    chk("t2_xfer", n_out, 1);
    chk("t2_halt", 32'(halted), 1);

    // 3: "," with late input
    do_reset(8'h0);
    load_rom(32'h5, 1);
    go();
    wait_sig("t3_ir", 1, 10);
    repeat (3) @(negedge clk);
    chk("t3_ir_hold", {bus.in_ready, n_wr[0]}, 2'b10);
    bus.in_data = 8'h7F; bus.in_valid = 1'b1;
    @(negedge clk) bus.in_valid = 1'b0;
    chk("t3_ir_drop", 32'(bus.in_ready), 0);
    wait_done("t3", 20);
    chk("t3_wr", n_wr, 1);
    chk("t3_wdata", 32'(last_wdata), 32'h7F);
    chk("t3_cell", 32'(tape[0]), 32'h7F);
    chk("t3_halt", 32'(halted), 1);

    // 4: "[ [ + ] > ] -" cell 0 -> skip to word 6
    do_reset(8'h0);
    load_rom(32'h03707266, 7);
    go();
    wait_done("t4", 200);
    chk("t4_cnt", {n_dec[7:0], n_inc[7:0], n_next[7:0]}, 24'h010000);
    chk("t4_pc", 32'(bus.pc_addr), 7);
    chk("t4_flags", {halted, err}, 2'b10);
    chk("t4_cell", 32'(tape[0]), 32'hFF);

    // 5: "+ + [ - ]" -> loop once, backward scan, halt at word 5
    do_reset(8'h0);
    load_rom(32'h00073622, 5);
    go();
    wait_done("t5", 300);
    chk("t5_dec", n_dec, 2);
    chk("t5_inc", n_inc, 2);
    chk("t5_fetch2", n_fetch2, 2);
    chk("t5_pc", 32'(bus.pc_addr), 5);
    chk("t5_flags", {halted, err, busy}, 3'b100);
    chk("t5_cell", 32'(tape[0]), 0);

    // 6: "]" at pc 0 with nonzero cell -> ERR
    do_reset(8'h01);
    load_rom(32'h7, 1);
    go();
    wait_done("t6", 20);
    chk("t6_err", {err, halted, busy}, 3'b100);
    repeat (3) @(negedge clk);
    chk("t6_sticky", 32'(err), 1);
    // restart from ERR, then reset mid-OUT_HS
    load_rom(32'h4, 1);
    go();
    chk("t6_clr", 32'(err), 0);
    wait_sig("t6_ov", 0, 10);
    rst = 1'b1;
    @(negedge clk);
    chk("t6_rst", {bus.out_valid, busy, halted, err}, 0);
    chk("t6_rst_out", 32'(bus.out_data), 0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("t6_idle", {busy, bus.prog_re}, 0);

    chk("one_strobe", n_multi, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
